stg4ma: RTL and testbench

- Pipeline stage 4 (memory access). Sits directly downstream of the execute stage and upstream of writeback.
- Registers execute-stage outputs and passes non-memory instructions through in one cycle.
- For load/store, runs a req/ack transaction on the data-memory port and stalls upstream stages until the transaction completes or times out.

---
 rtl/stg4ma_pkg.sv | 27 ++
 rtl/stg4ma_if.sv | 22 ++
 rtl/stg4ma.sv | 154 +++++++++++++++
 tb/tb_stg4ma.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stg4ma_pkg.sv
// Shared sizes and opcodes for the memory-access stage (stage 4).
package stg4ma_pkg;

    localparam int unsigned SIZE_ADDR   = 16;
    localparam int unsigned SIZE_DATA   = 24;
    localparam int unsigned SIZE_OPC    = 6;
    localparam int unsigned SIZE_TGT_GP = 4;
    localparam int unsigned SIZE_TGT_SR = 3;
    localparam int unsigned HBIT_ADDR   = SIZE_ADDR - 1;

    typedef logic [SIZE_ADDR-1:0]   addr_t;
    typedef logic [SIZE_DATA-1:0]   data_t;
    typedef logic [SIZE_OPC-1:0]    opc_t;
    typedef logic [SIZE_TGT_GP-1:0] tgt_gp_t;
    typedef logic [SIZE_TGT_SR-1:0] tgt_sr_t;

    // Opcode 0 doubles as the NOP bubble seen by writeback.
    localparam opc_t OPC_NOP  = 6'h00;
    localparam opc_t OPC_ADD  = 6'h01;
    localparam opc_t OPC_M_LD = 6'h30;
    localparam opc_t OPC_M_ST = 6'h31;

    function automatic logic is_mem_op(input opc_t opc);
        return (opc == OPC_M_LD) || (opc == OPC_M_ST);
    endfunction

endpackage

// File: rtl/stg4ma_if.sv
// Data-memory request/ack port between stage 4 (master) and the memory (slave).
interface stg4ma_if;
    import stg4ma_pkg::*;

    logic  ow_mem_req;
    logic  ow_mem_we;
    addr_t ow_mem_addr;
    data_t ow_mem_wdata;
    logic  iw_mem_ack;
    data_t iw_mem_rdata;

    modport master (
        output ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata,
        input  iw_mem_ack, iw_mem_rdata
    );

    modport slave (
        input  ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata,
        output iw_mem_ack, iw_mem_rdata
    );

endinterface

// File: rtl/stg4ma.sv
// Pipeline stage 4: registers execute results, runs LD/ST on the data-memory
// port and stalls upstream until ack or timeout.
module stg4ma
    import stg4ma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1)
) (
    input  logic    iw_clk,
    input  logic    iw_rst,
    input  addr_t   iw_pc,
    input  data_t   iw_instr,
    input  opc_t    iw_opc,
    input  tgt_gp_t iw_tgt_gp,
    input  tgt_sr_t iw_tgt_sr,
    input  data_t   iw_result,
    input  data_t   iw_st_data,
    output logic    ow_stall,
    stg4ma_if.master mem,
    output addr_t   ow_pc,
    output data_t   ow_instr,
    output opc_t    ow_opc,
    output tgt_gp_t ow_tgt_gp,
    output tgt_sr_t ow_tgt_sr,
    output data_t   ow_result,
    output logic    ow_fault
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    addr_t   pc_q;
    data_t   instr_q;
    opc_t    opc_q;
    tgt_gp_t tgt_gp_q;
    tgt_sr_t tgt_sr_q;
    data_t   result_q;
    logic    fault_q;

    logic    req_q;
    logic    we_q;
    addr_t   addr_q;
    data_t   wdata_q;

    logic    is_mem;
    logic    is_ld;
    logic    timeout;
    logic    done;

    always_comb begin
        is_mem   = is_mem_op(iw_opc);
        is_ld    = (iw_opc == OPC_M_LD);
        timeout  = (TIMEOUT_CYC != 0) && (state_q == WAIT) && (cnt_q == CNT_LAST);
        done     = mem.iw_mem_ack || timeout;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        ow_stall = ((state_q == IDLE) && is_mem) || ((state_q == WAIT) && !done);
    end

    // pc/instr hold their previous values across bubbles; only opc, targets
    // and result are cleared so writeback sees a NOP.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pc_q     <= '0;
            instr_q  <= '0;
            opc_q    <= '0;
            tgt_gp_q <= '0;
            tgt_sr_q <= '0;
            result_q <= '0;
            fault_q  <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            fault_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (is_mem) begin
                        req_q    <= 1'b1;
                        we_q     <= !is_ld;
                        addr_q   <= iw_result[HBIT_ADDR:0];
                        wdata_q  <= iw_st_data;
                        opc_q    <= OPC_NOP;
                        tgt_gp_q <= '0;
                        tgt_sr_q <= '0;
                        result_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= WAIT;
                    end else begin
                        pc_q     <= iw_pc;
                        instr_q  <= iw_instr;
                        opc_q    <= iw_opc;
                        tgt_gp_q <= iw_tgt_gp;
                        tgt_sr_q <= iw_tgt_sr;
                        result_q <= iw_result;
                    end
                end
                WAIT: begin
                    // Ack takes priority over a timeout landing on the same cycle.
                    if (mem.iw_mem_ack) begin
                        pc_q     <= iw_pc;
                        instr_q  <= iw_instr;
                        opc_q    <= iw_opc;
                        tgt_gp_q <= iw_tgt_gp;
                        tgt_sr_q <= iw_tgt_sr;
                        result_q <= is_ld ? mem.iw_mem_rdata : iw_result;
                        req_q    <= 1'b0;
                        state_q  <= IDLE;
                    end else if (timeout) begin
                        req_q    <= 1'b0;
                        fault_q  <= 1'b1;
                        opc_q    <= OPC_NOP;
                        tgt_gp_q <= '0;
                        tgt_sr_q <= '0;
                        result_q <= '0;
                        state_q  <= IDLE;
                    end else begin
                        opc_q    <= OPC_NOP;
                        tgt_gp_q <= '0;
                        tgt_sr_q <= '0;
                        result_q <= '0;
                        cnt_q    <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.ow_mem_req   = req_q;
    assign mem.ow_mem_we    = we_q;
    assign mem.ow_mem_addr  = addr_q;
    assign mem.ow_mem_wdata = wdata_q;

    assign ow_pc     = pc_q;
    assign ow_instr  = instr_q;
    assign ow_opc    = opc_q;
    assign ow_tgt_gp = tgt_gp_q;
    assign ow_tgt_sr = tgt_sr_q;
    assign ow_result = result_q;
    assign ow_fault  = fault_q;

endmodule

// File: tb/tb_stg4ma.sv
// Self-checking bench for stg4ma: directed table, reset mid-transaction, random ops.
module tb_stg4ma;
    import stg4ma_pkg::*;

    localparam int TMO = 4;

    logic    iw_clk = 1'b0;
    logic    iw_rst = 1'b1;
    addr_t   iw_pc = '0;
    data_t   iw_instr = '0;
    opc_t    iw_opc = '0;
    tgt_gp_t iw_tgt_gp = '0;
    tgt_sr_t iw_tgt_sr = '0;
    data_t   iw_result = '0;
    data_t   iw_st_data = '0;
    logic    ow_stall;
    addr_t   ow_pc;
    data_t   ow_instr;
    opc_t    ow_opc;
    tgt_gp_t ow_tgt_gp;
    tgt_sr_t ow_tgt_sr;
    data_t   ow_result;
    logic    ow_fault;

    stg4ma_if mif ();

    stg4ma #(.TIMEOUT_CYC(TMO)) dut (
        .iw_clk    (iw_clk),
        .iw_rst    (iw_rst),
        .iw_pc     (iw_pc),
        .iw_instr  (iw_instr),
        .iw_opc    (iw_opc),
        .iw_tgt_gp (iw_tgt_gp),
        .iw_tgt_sr (iw_tgt_sr),
        .iw_result (iw_result),
        .iw_st_data(iw_st_data),
        .ow_stall  (ow_stall),
        .mem       (mif),
        .ow_pc     (ow_pc),
        .ow_instr  (ow_instr),
        .ow_opc    (ow_opc),
        .ow_tgt_gp (ow_tgt_gp),
        .ow_tgt_sr (ow_tgt_sr),
        .ow_result (ow_result),
        .ow_fault  (ow_fault)
    );

    always #5 iw_clk = ~iw_clk;

    typedef struct {
        addr_t   pc;
        data_t   instr;
        opc_t    opc;
        tgt_gp_t tgt_gp;
        tgt_sr_t tgt_sr;
        data_t   result;
        data_t   st_data;
        data_t   rdata;
        int      ack_at;    // WAIT-cycle index carrying ack; -1 = never
        bit      stray;     // pulse ack while a non-memory op is in IDLE
        int      exp_lat;   // edges until the instruction leaves the stage
        data_t   exp_res;
        bit      exp_fault;
    } vec_t;

    int    n_checks = 0;
    int    n_errors = 0;
    string cur_tag = "";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h at %0t", cur_tag, name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: latency and final result from the stage's rules.
    function automatic vec_t model(input vec_t v);
        bit m;
        m = (v.opc == OPC_M_LD) || (v.opc == OPC_M_ST);
        v.exp_fault = 1'b0;
        if (!m) begin
            v.exp_lat = 1;
            v.exp_res = v.result;
        end else if (v.ack_at >= 0 && v.ack_at < TMO) begin
            v.exp_lat = v.ack_at + 2;
            v.exp_res = (v.opc == OPC_M_LD) ? v.rdata : v.result;
        end else begin
            v.exp_lat   = TMO + 1;
            v.exp_res   = '0;
            v.exp_fault = 1'b1;
        end
        return v;
    endfunction

    function automatic vec_t mk(input addr_t pc, input opc_t opc, input tgt_gp_t gp, input tgt_sr_t sr,
                                input data_t res, input data_t sd, input data_t rd, input int ack_at,
                                input bit stray, input int lat, input data_t eres, input bit ef);
        vec_t v;
        v.pc = pc; v.instr = {8'hA5, pc}; v.opc = opc; v.tgt_gp = gp; v.tgt_sr = sr;
        v.result = res; v.st_data = sd; v.rdata = rd; v.ack_at = ack_at; v.stray = stray;
        v.exp_lat = lat; v.exp_res = eres; v.exp_fault = ef;
        return v;
    endfunction

    // Entered just after a rising edge; leaves just after the edge retiring v.
    task automatic run(input vec_t v);
        bit m;
        bit st;
        m  = (v.opc == OPC_M_LD) || (v.opc == OPC_M_ST);
        st = (v.opc == OPC_M_ST);
        iw_pc = v.pc; iw_instr = v.instr; iw_opc = v.opc; iw_tgt_gp = v.tgt_gp;
        iw_tgt_sr = v.tgt_sr; iw_result = v.result; iw_st_data = v.st_data;
        for (int c = 0; c < v.exp_lat; c++) begin
            mif.iw_mem_ack   = 1'b0;
            mif.iw_mem_rdata = data_t'($urandom);
            if (!m && v.stray && c == 0) mif.iw_mem_ack = 1'b1;
            if (m && c >= 1 && c - 1 == v.ack_at) begin
                mif.iw_mem_ack   = 1'b1;
                mif.iw_mem_rdata = v.rdata;
            end
            @(negedge iw_clk);
            chk("stall", ow_stall, c < v.exp_lat - 1);
            @(posedge iw_clk);
            #1;
            mif.iw_mem_ack = 1'b0;
            if (c + 1 < v.exp_lat) begin
                chk("bub_opc", ow_opc, 0);
                chk("bub_gp", ow_tgt_gp, 0);
                chk("bub_sr", ow_tgt_sr, 0);
                chk("bub_res", ow_result, 0);
                chk("req_hi", mif.ow_mem_req, 1);
                chk("fault_lo", ow_fault, 0);
            end else if (v.exp_fault) begin
                chk("tmo_opc", ow_opc, 0);
                chk("tmo_gp", ow_tgt_gp, 0);
                chk("tmo_res", ow_result, 0);
                chk("tmo_req", mif.ow_mem_req, 0);
                chk("tmo_fault", ow_fault, 1);
            end else begin
                chk("pc", ow_pc, v.pc);
                chk("instr", ow_instr, v.instr);
                chk("opc", ow_opc, v.opc);
                chk("gp", ow_tgt_gp, v.tgt_gp);
                chk("sr", ow_tgt_sr, v.tgt_sr);
                chk("result", ow_result, v.exp_res);
                chk("req_lo", mif.ow_mem_req, 0);
                chk("fault", ow_fault, 0);
            end
            if (m) begin
                chk("we", mif.ow_mem_we, st);
                chk("addr", mif.ow_mem_addr, v.result[HBIT_ADDR:0]);
                chk("wdata", mif.ow_mem_wdata, v.st_data);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   r;

        mif.iw_mem_ack   = 1'b0;
        mif.iw_mem_rdata = '0;

        cur_tag = "reset";
        #3;
        chk("req", mif.ow_mem_req, 0);
        chk("opc", ow_opc, 0);
        chk("result", ow_result, 0);
        chk("pc", ow_pc, 0);
        chk("fault", ow_fault, 0);
        chk("stall", ow_stall, 0);
        @(negedge iw_clk);
        iw_rst = 1'b0;
        @(posedge iw_clk);
        #1;

        //        pc       opc       gp  sr  result      st_data     rdata       ack stray lat exp_res     fault
        tbl.push_back(mk(16'h0100, OPC_ADD,  3, 1, 24'h000123, 24'h000000, 24'h000000, -1, 0, 1, 24'h000123, 0));
        tbl.push_back(mk(16'h0104, OPC_M_LD, 5, 0, 24'h000040, 24'h000000, 24'hABCDEF,  3, 0, 5, 24'hABCDEF, 0));
        tbl.push_back(mk(16'h0108, OPC_M_ST, 0, 0, 24'h000010, 24'h000055, 24'h000000,  0, 0, 2, 24'h000010, 0));
        tbl.push_back(mk(16'h010C, OPC_M_LD, 7, 2, 24'h000020, 24'h000000, 24'h123456,  0, 0, 2, 24'h123456, 0));
        tbl.push_back(mk(16'h0110, OPC_ADD,  1, 0, 24'h0000FF, 24'h000000, 24'h000000, -1, 1, 1, 24'h0000FF, 0));
        tbl.push_back(mk(16'h0114, OPC_M_LD, 2, 0, 24'h000080, 24'h000000, 24'h999999, -1, 0, 5, 24'h000000, 1));
        tbl.push_back(mk(16'h0118, OPC_M_ST, 4, 3, 24'h000088, 24'h0000AA, 24'h000000,  3, 0, 5, 24'h000088, 0));
        tbl.push_back(mk(16'h011C, OPC_ADD,  9, 7, 24'h000777, 24'h000000, 24'h000000, -1, 1, 1, 24'h000777, 0));

        foreach (tbl[i]) begin
            cur_tag = $sformatf("vec%0d", i);
            run(tbl[i]);
        end

        cur_tag = "rst_mid";
        iw_opc = OPC_M_LD; iw_result = 24'h000040; iw_tgt_gp = 4'd6;
        @(posedge iw_clk);
        #1;
        chk("req_before", mif.ow_mem_req, 1);
        @(posedge iw_clk);
        #3;
        iw_rst = 1'b1;
        #1;
        chk("req", mif.ow_mem_req, 0);
        chk("opc", ow_opc, 0);
        chk("result", ow_result, 0);
        chk("pc", ow_pc, 0);
        chk("gp", ow_tgt_gp, 0);
        iw_opc = OPC_NOP;
        @(negedge iw_clk);
        iw_rst = 1'b0;
        @(posedge iw_clk);
        #1;
        cur_tag = "post_rst";
        run(mk(16'h0200, OPC_ADD, 8, 5, 24'h00ABCD, 24'h0, 24'h0, -1, 0, 1, 24'h00ABCD, 0));

        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 2));
            v.pc      = addr_t'($urandom);
            v.instr   = data_t'($urandom);
            v.opc     = (r == 0) ? OPC_M_LD : (r == 1) ? OPC_M_ST : opc_t'($urandom_range(1, 47));
            v.tgt_gp  = tgt_gp_t'($urandom);
            v.tgt_sr  = tgt_sr_t'($urandom);
            v.result  = data_t'($urandom);
            v.st_data = data_t'($urandom);
            v.rdata   = data_t'($urandom);
            v.ack_at  = int'($urandom_range(0, 6)) - 1;
            v.stray   = bit'($urandom_range(0, 1));
            v = model(v);
            cur_tag = $sformatf("rnd%0d", i);
            run(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
